// File: rtl/mem_responder.sv
// Fixed-latency memory responder: serves fetch and load-word requests one at a time
// from bench-writable program/data stores. Define DMEM_PRESET_EN to preset the data store.
module mem_responder #(
  parameter int unsigned IMEM_DEPTH   = 16,
  parameter int unsigned DMEM_DEPTH   = 8,
  parameter int unsigned READ_LATENCY = 2
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          if_req,
  input  logic [$clog2(IMEM_DEPTH)-1:0] if_addr,
  output logic                          if_valid,
  output logic [31:0]                   if_instr,
  input  logic                          ld_req,
  input  logic [7:0]                    ld_addr,
  output logic                          ld_valid,
  output logic [7:0]                    ld_data,
  output logic                          ld_err,
  output logic                          busy,
  input  logic                          prog_we,
  input  logic [$clog2(IMEM_DEPTH)-1:0] prog_addr,
  input  logic [31:0]                   prog_data,
  input  logic                          dm_we,
  input  logic [7:0]                    dm_addr,
  input  logic [7:0]                    dm_wdata
);

  localparam int unsigned DA_W  = $clog2(DMEM_DEPTH);
  localparam int unsigned CNT_W = 3;

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_e;

  typedef struct packed {
    logic        is_ld;
    logic        err;
    logic [31:0] data;
  } rsp_t;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  rsp_t               rsp_q, rsp_d;
  logic               if_valid_q, if_valid_d;
  logic               ld_valid_q, ld_valid_d;
  logic [31:0]        if_instr_q, if_instr_d;
  logic [7:0]         ld_data_q, ld_data_d;
  logic               ld_err_q, ld_err_d;
  logic               busy_q, busy_d;
  logic [31:0]        imem_q [IMEM_DEPTH];
  logic [31:0]        imem_d [IMEM_DEPTH];
  logic [7:0]         dmem_q [DMEM_DEPTH];
  logic [7:0]         dmem_d [DMEM_DEPTH];

  logic if_mapped, ld_mapped, dm_mapped, accept;

  assign if_mapped = 32'(if_addr) < IMEM_DEPTH;
  assign ld_mapped = 32'(ld_addr) < DMEM_DEPTH;
  assign dm_mapped = 32'(dm_addr) < DMEM_DEPTH;

  // Store writes are independent of the request FSM
  always_comb begin
    imem_d = imem_q;
    dmem_d = dmem_q;
    if (prog_we) imem_d[prog_addr] = prog_data;
    if (dm_we && dm_mapped) dmem_d[dm_addr[DA_W-1:0]] = dm_wdata;
  end

  // Request FSM: read data is captured at accept, so later writes cannot alter it
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    rsp_d      = rsp_q;
    if_valid_d = 1'b0;
    ld_valid_d = 1'b0;
    if_instr_d = if_instr_q;
    ld_data_d  = ld_data_q;
    ld_err_d   = ld_err_q;
    busy_d     = busy_q;
    accept     = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (ld_req) begin
          accept      = 1'b1;
          rsp_d.is_ld = 1'b1;
          rsp_d.err   = !ld_mapped;
          rsp_d.data  = ld_mapped ? 32'(dmem_q[ld_addr[DA_W-1:0]]) : 32'h0;
        end else if (if_req) begin
          accept      = 1'b1;
          rsp_d.is_ld = 1'b0;
          rsp_d.err   = 1'b0;
          rsp_d.data  = if_mapped ? imem_q[if_addr] : 32'h0;
        end
        if (accept) begin
          cnt_d   = CNT_W'(READ_LATENCY - 1);
          state_d = (READ_LATENCY == 1) ? S_RESP : S_WAIT;
          busy_d  = 1'b1;
        end
      end
      S_WAIT: begin
        if (cnt_q == '0) state_d = S_RESP;
        else             cnt_d   = cnt_q - CNT_W'(1);
      end
      S_RESP: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
      end
      default: state_d = S_IDLE;
    endcase

    // Registered response outputs update on entry to RESP
    if (state_d == S_RESP && state_q != S_RESP) begin
      if (rsp_d.is_ld) begin
        ld_valid_d = 1'b1;
        ld_data_d  = rsp_d.data[7:0];
        ld_err_d   = rsp_d.err;
      end else begin
        if_valid_d = 1'b1;
        if_instr_d = rsp_d.data;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      rsp_q      <= '0;
      if_valid_q <= 1'b0;
      ld_valid_q <= 1'b0;
      if_instr_q <= '0;
      ld_data_q  <= '0;
      ld_err_q   <= 1'b0;
      busy_q     <= 1'b0;
      imem_q     <= '{default: '0};
`ifdef DMEM_PRESET_EN
      dmem_q     <= '{0: 8'hEC, 1: 8'h0A, 2: 8'h02, default: 8'h00};
`else
      dmem_q     <= '{default: '0};
`endif
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      rsp_q      <= rsp_d;
      if_valid_q <= if_valid_d;
      ld_valid_q <= ld_valid_d;
      if_instr_q <= if_instr_d;
      ld_data_q  <= ld_data_d;
      ld_err_q   <= ld_err_d;
      busy_q     <= busy_d;
      imem_q     <= imem_d;
      dmem_q     <= dmem_d;
    end
  end

  assign if_valid = if_valid_q;
  assign if_instr = if_instr_q;
  assign ld_valid = ld_valid_q;
  assign ld_data  = ld_data_q;
  assign ld_err   = ld_err_q;
  assign busy     = busy_q;

endmodule

// File: tb/tb_mem_responder.sv
// Bench for mem_responder: cycle-level reference model plus directed and random requests.
module tb_mem_responder;

  localparam int unsigned RL = 2;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        if_req, ld_req, prog_we, dm_we;
  logic [3:0]  if_addr, prog_addr;
  logic [7:0]  ld_addr, dm_addr, dm_wdata;
  logic [31:0] prog_data;
  logic        if_valid, ld_valid, ld_err, busy;
  logic [31:0] if_instr;
  logic [7:0]  ld_data;

  mem_responder #(.IMEM_DEPTH(16), .DMEM_DEPTH(8), .READ_LATENCY(RL)) dut (
    .clk(clk), .rst_n(rst_n),
    .if_req(if_req), .if_addr(if_addr), .if_valid(if_valid), .if_instr(if_instr),
    .ld_req(ld_req), .ld_addr(ld_addr), .ld_valid(ld_valid), .ld_data(ld_data),
    .ld_err(ld_err), .busy(busy),
    .prog_we(prog_we), .prog_addr(prog_addr), .prog_data(prog_data),
    .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata)
  );

  always #5 clk = ~clk;

  int ntests = 0;
  int nfail  = 0;
  int bcount = 0;
  bit rand_wr = 0;

  function automatic void chk(string nm, logic [31:0] act, logic [31:0] exp);
    ntests++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endfunction

  // Reference model: absolute cycle numbers, response due RL edges after accept,
  // and the first edge after a response is not an accept opportunity.
  logic [31:0] m_im [16];
  logic [7:0]  m_dm [8];
  int          cyc, acc_cyc, free_cyc;
  bit          pend, p_ld, p_err;
  logic [31:0] p_data;
  logic        e_ifv, e_ldv, e_busy, e_lderr;
  logic [31:0] e_instr;
  logic [7:0]  e_ldd;

  task automatic reset_model();
    for (int i = 0; i < 16; i++) m_im[i] = '0;
    for (int i = 0; i < 8; i++) m_dm[i] = '0;
`ifdef DMEM_PRESET_EN
    m_dm[0] = 8'hEC; m_dm[1] = 8'h0A; m_dm[2] = 8'h02;
`endif
    cyc = 0; acc_cyc = 0; free_cyc = 0; pend = 0;
    e_ifv = 0; e_ldv = 0; e_busy = 0; e_lderr = 0; e_instr = '0; e_ldd = '0;
  endtask

  task automatic model_step();
    cyc++;
    e_ifv = 0;
    e_ldv = 0;
    if (pend && cyc == acc_cyc + int'(RL)) begin
      pend = 0;
      free_cyc = cyc + 2;
      if (p_ld) begin e_ldv = 1; e_ldd = p_data[7:0]; e_lderr = p_err; end
      else      begin e_ifv = 1; e_instr = p_data; end
    end else if (!pend && cyc >= free_cyc && (ld_req || if_req)) begin
      pend = 1;
      acc_cyc = cyc;
      if (ld_req) begin
        p_ld = 1;
        p_err = (ld_addr >= 8);
        p_data = p_err ? 32'h0 : {24'h0, m_dm[ld_addr[2:0]]};
      end else begin
        p_ld = 0;
        p_err = 0;
        p_data = m_im[if_addr];
      end
    end
    e_busy = pend || e_ifv || e_ldv;
    if (prog_we) m_im[prog_addr] = prog_data;
    if (dm_we && dm_addr < 8) m_dm[dm_addr[2:0]] = dm_wdata;
  endtask

  initial begin
    reset_model();
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) reset_model();
      else        model_step();
    end
  end

  // Per-cycle compare, sampled mid-cycle
  initial begin
    forever begin
      @(negedge clk);
      chk("if_valid", 32'(if_valid), 32'(e_ifv));
      chk("ld_valid", 32'(ld_valid), 32'(e_ldv));
      chk("busy", 32'(busy), 32'(e_busy));
      chk("if_instr", if_instr, e_instr);
      chk("ld_data", 32'(ld_data), 32'(e_ldd));
      if (e_ldv) chk("ld_err", 32'(ld_err), 32'(e_lderr));
      if (busy) bcount++;
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
    if (rand_wr) begin
      prog_we   = ($urandom_range(0, 3) == 0);
      prog_addr = 4'($urandom);
      prog_data = $urandom;
      dm_we     = ($urandom_range(0, 2) == 0);
      dm_addr   = 8'($urandom_range(0, 11));
      dm_wdata  = 8'($urandom);
    end
  endtask

  task automatic wr_prog(input logic [3:0] a, input logic [31:0] d);
    prog_we = 1; prog_addr = a; prog_data = d;
    tick();
    prog_we = 0;
  endtask

  task automatic wr_dm(input logic [7:0] a, input logic [7:0] d);
    dm_we = 1; dm_addr = a; dm_wdata = d;
    tick();
    dm_we = 0;
  endtask

  // Requester: holds each req until its valid pulse, bounded wait
  task automatic xact(input bit dl, input bit di, input logic [7:0] la, input logic [3:0] ia,
                      output logic [7:0] ldd, output logic lde, output logic [31:0] ins,
                      output int n_ld, output int n_if);
    int n;
    n = 0; n_ld = -1; n_if = -1; ldd = '0; lde = 0; ins = '0;
    ld_req = dl; ld_addr = la; if_req = di; if_addr = ia;
    while ((ld_req || if_req) && n < 40) begin
      tick();
      n++;
      if (ld_valid) begin ld_req = 0; ldd = ld_data; lde = ld_err; n_ld = n; end
      if (if_valid) begin if_req = 0; ins = if_instr; n_if = n; end
    end
    if (ld_req || if_req) begin
      chk("xact_timeout", 32'(n), 32'(0));
      ld_req = 0; if_req = 0;
    end
  endtask

  logic [7:0]  r_ldd;
  logic        r_lde;
  logic [31:0] r_ins;
  int          n_ld, n_if, b0, n, vseen;

  initial begin
    rst_n = 0; if_req = 0; ld_req = 0; prog_we = 0; dm_we = 0;
    if_addr = '0; ld_addr = '0; prog_addr = '0; prog_data = '0; dm_addr = '0; dm_wdata = '0;
    repeat (2) @(posedge clk);
    #2 rst_n = 1;
    chk("rst_busy", 32'(busy), 32'h0);
    chk("rst_if_instr", if_instr, 32'h0);

    // Fetch latency, data and busy span
    wr_prog(4'd3, 32'h8C04_0001);
    b0 = bcount;
    xact(0, 1, 8'd0, 4'd3, r_ldd, r_lde, r_ins, n_ld, n_if);
    chk("t1_instr", r_ins, 32'h8C04_0001);
    chk("t1_latency", 32'(n_if), 32'd3);
    tick(); tick();
    chk("t1_busy_cycles", 32'(bcount - b0), 32'd3);

    // Operand loads
    wr_dm(8'd0, 8'hEC); wr_dm(8'd1, 8'd10); wr_dm(8'd2, 8'd2);
    xact(1, 0, 8'd0, 4'd0, r_ldd, r_lde, r_ins, n_ld, n_if);
    chk("t2_ld0", 32'(r_ldd), 32'hEC);
    chk("t2_err0", 32'(r_lde), 32'h0);
    xact(1, 0, 8'd2, 4'd0, r_ldd, r_lde, r_ins, n_ld, n_if);
    chk("t2_ld2", 32'(r_ldd), 32'h02);

    // Unmapped load
    xact(1, 0, 8'd9, 4'd0, r_ldd, r_lde, r_ins, n_ld, n_if);
    chk("t3_data", 32'(r_ldd), 32'h0);
    chk("t3_err", 32'(r_lde), 32'h1);

    // Simultaneous requests: load first, fetch after a full turnaround
    wr_prog(4'd0, 32'hCAFE_0000);
    xact(1, 1, 8'd1, 4'd0, r_ldd, r_lde, r_ins, n_ld, n_if);
    chk("t4_ld", 32'(r_ldd), 32'd10);
    chk("t4_instr", r_ins, 32'hCAFE_0000);
    chk("t4_order", 32'(n_if - n_ld), 32'd4);

    // Write during WAIT does not affect pending response
    ld_req = 1; ld_addr = 8'd1;
    tick();
    dm_we = 1; dm_addr = 8'd1; dm_wdata = 8'h7F;
    tick();
    dm_we = 0;
    n = 0;
    while (!ld_valid && n < 20) begin tick(); n++; end
    chk("t5_pending", 32'(ld_data), 32'd10);
    ld_req = 0;
    tick();
    xact(1, 0, 8'd1, 4'd0, r_ldd, r_lde, r_ins, n_ld, n_if);
    chk("t5_next", 32'(r_ldd), 32'h7F);

    // Reset mid-transaction drops the response
    wr_prog(4'd5, 32'h1234_5678);
    if_req = 1; if_addr = 4'd5;
    tick(); tick();
    rst_n = 0;
    tick();
    rst_n = 1; if_req = 0;
    chk("t6_busy", 32'(busy), 32'h0);
    chk("t6_instr", if_instr, 32'h0);
    vseen = 0;
    repeat (6) begin tick(); if (if_valid || ld_valid) vseen++; end
    chk("t6_no_valid", 32'(vseen), 32'h0);
    wr_prog(4'd5, 32'h1234_5678);
    xact(0, 1, 8'd0, 4'd5, r_ldd, r_lde, r_ins, n_ld, n_if);
    chk("t6_refetch", r_ins, 32'h1234_5678);

    // Random traffic with concurrent store writes
    rand_wr = 1;
    for (int t = 0; t < 300; t++) begin
      int k;
      k = $urandom_range(0, 2);
      xact(k != 1, k != 0, 8'($urandom_range(0, 11)), 4'($urandom), r_ldd, r_lde, r_ins, n_ld, n_if);
      repeat ($urandom_range(0, 2)) tick();
    end
    rand_wr = 0;
    prog_we = 0; dm_we = 0;
    repeat (4) tick();

    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end

endmodule
